dmem_dump_reader: RTL and testbench
===================================

// Module: dmem_dump_reader
// PURPOSE
//   Post-run hardware reader for data memory. On start, it walks a word-aligned range of dmemory through a
//   synchronous read port and streams each word out over a valid/ready interface. It is the on-chip counterpart
//   of the bench-side memory checks (min/max words, sorted-list words). It sits beside the CPU on the dmemory
//   debug read port.
// PARAMETERS
//   ADDR_WIDTH  10  byte-address width of dmemory (1 KiB); addresses wrap modulo 2**ADDR_WIDTH
//   DATA_WIDTH  32  word width; fixed at 32, other values unsupported
// PORTS
//   clk         in   1             single clock, rising edge
//   reset_n     in   1             asynchronous, active-low reset
//   start       in   1             request a dump; sampled only in IDLE
//   base_addr   in   ADDR_WIDTH    byte address of first word; bits[1:0] must be 0
//   word_count  in   ADDR_WIDTH-1  number of words to emit; 0 is legal
//   busy        out  1             high in every state except IDLE
//   done        out  1             one-cycle pulse when the dump finishes or is rejected
//   error       out  1             sticky misaligned-base flag; cleared by the next accepted start
//   mem_rd_en   out  1             dmemory read strobe
//   mem_addr    out  ADDR_WIDTH    dmemory byte address, word aligned
//   mem_rdata   in   DATA_WIDTH    dmemory read data, valid one cycle after mem_rd_en
//   out_valid   out  1             out_data/out_index hold a word
//   out_ready   in   1             consumer accepts the word
//   out_data    out  DATA_WIDTH    word read from memory
//   out_index   out  ADDR_WIDTH-1  0-based position of the word within the dump
//   checksum    out  DATA_WIDTH    present only with DUMP_CHECKSUM_EN
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; all outputs 0; internal counters 0.
//   FSM states: IDLE -> READ -> CAPT -> HOLD -> (READ | FIN) -> IDLE.
//   - IDLE: on start=1:
//       if base_addr[1:0]!=0: set error=1 and go to FIN (no reads).
//       else if word_count=0: go to FIN.
//       else: latch base and count, clear error, go to READ.
//   - READ: mem_rd_en=1 and mem_addr=cur_addr for exactly this one cycle; go to CAPT.
//   - CAPT: register mem_rdata into out_data; out_valid=1 from the next cycle; go to HOLD.
//   - HOLD: out_valid=1. out_data and out_index stay stable until out_valid&out_ready.
//       On handshake: cur_addr+=4 (mod 2**ADDR_WIDTH); index+=1; out_valid drops the next cycle.
//       If more words remain, go to READ; else go to FIN.
//   - FIN: done=1 for one cycle; go to IDLE.
//   Latency: out_valid rises 2 edges after the accepting start edge. Steady rate is 1 word per 3 cycles
//     when out_ready=1.
//   start while busy: ignored; the dump in progress is not disturbed.
//   out_ready while out_valid=0: ignored.
//   Address wrap: last word at 2**ADDR_WIDTH-4 is followed by address 0; no error is raised.
//   Reset mid-dump: immediate IDLE; any partially streamed dump is discarded with no done pulse.
// CONFIGURATION
//   DUMP_CHECKSUM_EN defined:
//     - 32-bit wrap-around sum of every word accepted in HOLD is output on checksum.
//     - Zeroed on accepted start; stable from the done pulse until the next accepted start; 0 after reset.
//   DUMP_CHECKSUM_EN undefined: no checksum port, no adder logic; all other behaviour identical.
// STRUCTURE
//   - State encodings (IDLE/READ/CAPT/HOLD/FIN, 3-bit) and the word stride 4 go in the shared constants
//     header _const.v.
//   - One sub-module, dump_out_stage: the out_data/out_index/out_valid holding register and the
//     handshake logic.
//   - The FSM, address/count logic and checksum stay in dmem_dump_reader.
// TESTING
//   1. Preload words 0..9 = -300,-10,-7,0,2,3,9,12,18,999; base=0, count=10, out_ready=1
//      -> 10 words in order, out_index 0..9, one done pulse.
//      With DUMP_CHECKSUM_EN: checksum=32'h000002D6.
//   2. Same preload; out_ready low 3 cycles on word 4
//      -> out_data=32'd2 and out_index=4 stay stable; no word is lost or duplicated.
//   3. count=0 -> done pulse 2 edges after start; out_valid and mem_rd_en never asserted; error=0.
//   4. base=10'h1F2 -> error=1 and done pulse, no reads.
//      A following start with base=10'h1F4, count=1 -> error=0 and one word from 0x1F4.
//   5. base=10'h3FC, count=2 -> mem_addr sequence 0x3FC then 0x000; two words streamed.
//   6. reset_n low during HOLD of word 3
//      -> all outputs 0 asynchronously; after release, a new start with count=1 dumps normally.

Source files
------------

// File: rtl/dmem_dump_reader_pkg.sv
// dmem_dump_reader_pkg: shared FSM state encodings and word stride for the dmemory dump reader.
package dmem_dump_reader_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    HOLD = 3'd3,
    FIN  = 3'd4
  } state_t;
  localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/dump_out_stage.sv
// dump_out_stage: holding register for one streamed word plus its index, released by valid/ready handshake.
module dump_out_stage #(
  parameter int IW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [IW-1:0] load_index,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [IW-1:0] index,
  output logic          fire
);
  assign fire = valid & ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      index <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      index <= load_index;
    end else if (fire) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: walks a word-aligned dmemory range and streams each word over valid/ready.
// Optional DUMP_CHECKSUM_EN adds a running 32-bit sum of accepted words on the checksum port.
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-2:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-2:0] out_index
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-2:0] remaining, idx;
  logic fire, bad_base, empty, accept, capt;
  assign bad_base  = base_addr[1:0] != 2'b00;
  assign empty     = word_count == '0;
  assign accept    = state == IDLE && start && !bad_base && !empty;
  assign capt      = state == CAPT;
  assign busy      = state != IDLE;
  assign mem_rd_en = state == READ;
  assign mem_addr  = mem_rd_en ? cur_addr : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (bad_base || empty) ? FIN : READ;
      READ:    state_nx = CAPT;
      CAPT:    state_nx = HOLD;
      HOLD:    state_nx = !fire ? HOLD : (remaining == (ADDR_WIDTH-1)'(1)) ? FIN : READ;
      default: state_nx = IDLE;
    endcase
  end
  // done trails FIN by one edge so it lands two edges after an immediate-finish start
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      done      <= 1'b0;
      error     <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      idx       <= '0;
    end else begin
      done <= state == FIN;
      if (state == IDLE && start && bad_base) error <= 1'b1;
      if (accept) begin
        error     <= 1'b0;
        cur_addr  <= base_addr;
        remaining <= word_count;
        idx       <= '0;
      end
      if (fire) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(WORD_STRIDE);
        remaining <= remaining - 1'b1;
        idx       <= idx + 1'b1;
      end
    end
`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) checksum <= '0;
    else if (accept) checksum <= '0;
    else if (fire) checksum <= checksum + out_data;
`endif
  dump_out_stage #(.IW(ADDR_WIDTH-1), .DW(DATA_WIDTH)) u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (capt),
    .load_data  (mem_rdata),
    .load_index (idx),
    .ready      (out_ready),
    .valid      (out_valid),
    .data       (out_data),
    .index      (out_index),
    .fire       (fire)
  );
endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb_dmem_dump_reader: directed self-checking bench for dmem_dump_reader with a behavioural dmemory.
module tb_dmem_dump_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        busy, done, error, mem_rd_en, out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] out_data;
  logic [8:0]  out_index;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [31:0] mem [256];
  logic [31:0] q_data [$];
  logic [8:0]  q_idx [$];
  logic [9:0]  q_addr [$];
  int done_cnt = 0;
  int vcnt = 0;
  int cmp = 0;
  int bad = 0;
  int exp_w [10] = '{-300, -10, -7, 0, 2, 3, 9, 12, 18, 999};

  dmem_dump_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index)
`ifdef DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[9:2]];

  // inputs only change on the falling edge, so 1 ns later shows what the next rising edge will use
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin q_data.push_back(out_data); q_idx.push_back(out_index); end
    if (mem_rd_en) q_addr.push_back(mem_addr);
    if (done) done_cnt++;
    if (out_valid) vcnt++;
  end

  task automatic clear_logs();
    q_data.delete(); q_idx.delete(); q_addr.delete();
    done_cnt = 0; vcnt = 0;
  endtask

  task automatic kick(input logic [9:0] b, input logic [8:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 300) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    cmp++;
    if (done_cnt !== 1) begin bad++; $display("FAIL %s done_pulses got=%0d want=1", tag, done_cnt); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    cmp++;
    if ({busy, done, error, mem_rd_en, out_valid} !== 5'b0 || mem_addr !== 10'd0 || out_data !== 32'd0 || out_index !== 9'd0) begin
      bad++; $display("FAIL reset outs busy=%b done=%b err=%b rd=%b v=%b addr=%h data=%h idx=%0d want all 0",
        busy, done, error, mem_rd_en, out_valid, mem_addr, out_data, out_index);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    clear_logs();
    out_ready = 1'b1;
    kick(10'h000, 9'd10);
    cmp++;
    if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b want=1", busy); end
    @(negedge clk);
    cmp++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_e1 out_valid got=%b want=0", out_valid); end
    @(negedge clk);
    cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'(exp_w[0])) begin
      bad++; $display("FAIL lat_e2 out_valid=%b data=%h want 1/%h", out_valid, out_data, 32'(exp_w[0]));
    end
    wait_done("stream");
    cmp++;
    if (q_data.size() !== 10) begin bad++; $display("FAIL stream count got=%0d want=10", q_data.size()); end
    else for (int i = 0; i < 10; i++) begin
      cmp++;
      if (q_data[i] !== 32'(exp_w[i]) || q_idx[i] !== 9'(i)) begin
        bad++; $display("FAIL stream word%0d data=%h idx=%0d want %h/%0d", i, q_data[i], q_idx[i], 32'(exp_w[i]), i);
      end
    end
    cmp++;
    if (busy !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL stream end busy=%b err=%b want 0/0", busy, error); end
`ifdef DUMP_CHECKSUM_EN
    cmp++;
    if (checksum !== 32'h000002D6) begin bad++; $display("FAIL checksum got=%h want=000002d6", checksum); end
`endif
  endtask

  task automatic test_backpressure();
    int k = 0;
    clear_logs();
    out_ready = 1'b1;
    kick(10'h000, 9'd10);
    while (!(out_valid && out_index == 9'd4) && k < 100) begin @(negedge clk); k++; end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'd2 || out_index !== 9'd4) begin
        bad++; $display("FAIL stall c%0d v=%b data=%h idx=%0d want 1/00000002/4", c, out_valid, out_data, out_index);
      end
    end
    out_ready = 1'b1;
    wait_done("stall");
    cmp++;
    if (q_data.size() !== 10) begin bad++; $display("FAIL stall count got=%0d want=10", q_data.size()); end
    else for (int i = 0; i < 10; i++) begin
      cmp++;
      if (q_data[i] !== 32'(exp_w[i]) || q_idx[i] !== 9'(i)) begin
        bad++; $display("FAIL stall word%0d data=%h idx=%0d want %h/%0d", i, q_data[i], q_idx[i], 32'(exp_w[i]), i);
      end
    end
  endtask

  task automatic test_zero_count();
    clear_logs();
    kick(10'h000, 9'd0);
    cmp++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero done_e1 got=%b want=0", done); end
    @(negedge clk);
    cmp++;
    if (done !== 1'b1) begin bad++; $display("FAIL zero done_e2 got=%b want=1", done); end
    repeat (3) @(negedge clk);
    cmp++;
    if (q_addr.size() !== 0 || vcnt !== 0 || error !== 1'b0 || done_cnt !== 1) begin
      bad++; $display("FAIL zero side reads=%0d valids=%0d err=%b dones=%0d want 0/0/0/1", q_addr.size(), vcnt, error, done_cnt);
    end
  endtask

  task automatic test_misaligned();
    clear_logs();
    kick(10'h1F2, 9'd5);
    wait_done("misalign");
    cmp++;
    if (error !== 1'b1 || q_addr.size() !== 0 || vcnt !== 0) begin
      bad++; $display("FAIL misalign err=%b reads=%0d valids=%0d want 1/0/0", error, q_addr.size(), vcnt);
    end
    clear_logs();
    kick(10'h1F4, 9'd1);
    wait_done("realign");
    cmp++;
    if (error !== 1'b0 || q_data.size() !== 1 || q_addr.size() !== 1) begin
      bad++; $display("FAIL realign err=%b words=%0d reads=%0d want 0/1/1", error, q_data.size(), q_addr.size());
    end else begin
      cmp++;
      if (q_addr[0] !== 10'h1F4 || q_data[0] !== 32'hCAFE0001) begin
        bad++; $display("FAIL realign addr=%h data=%h want 1f4/cafe0001", q_addr[0], q_data[0]);
      end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    kick(10'h3FC, 9'd2);
    wait_done("wrap");
    cmp++;
    if (q_addr.size() !== 2 || q_data.size() !== 2) begin
      bad++; $display("FAIL wrap reads=%0d words=%0d want 2/2", q_addr.size(), q_data.size());
    end else begin
      cmp++;
      if (q_addr[0] !== 10'h3FC || q_addr[1] !== 10'h000 || q_data[0] !== 32'h5A5A0FFC || q_data[1] !== 32'(exp_w[0])) begin
        bad++; $display("FAIL wrap addr=%h,%h data=%h,%h want 3fc,000 5a5a0ffc,%h",
          q_addr[0], q_addr[1], q_data[0], q_data[1], 32'(exp_w[0]));
      end
      cmp++;
      if (error !== 1'b0) begin bad++; $display("FAIL wrap err got=%b want=0", error); end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_logs();
    out_ready = 1'b0;
    kick(10'h000, 9'd10);
    out_ready = 1'b1;
    while (!(out_valid && out_index == 9'd3) && k < 100) begin
      @(negedge clk);
      k++;
      if (out_valid && out_index == 9'd3) out_ready = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    cmp++;
    if ({busy, done, error, mem_rd_en, out_valid} !== 5'b0 || mem_addr !== 10'd0 || out_data !== 32'd0 || out_index !== 9'd0) begin
      bad++; $display("FAIL midreset outs busy=%b done=%b err=%b rd=%b v=%b addr=%h data=%h idx=%0d want all 0",
        busy, done, error, mem_rd_en, out_valid, mem_addr, out_data, out_index);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    clear_logs();
    kick(10'h010, 9'd1);
    wait_done("after_reset");
    cmp++;
    if (q_data.size() !== 1 || q_addr.size() !== 1) begin
      bad++; $display("FAIL after_reset words=%0d reads=%0d want 1/1", q_data.size(), q_addr.size());
    end else begin
      cmp++;
      if (q_data[0] !== 32'd2 || q_idx[0] !== 9'd0 || q_addr[0] !== 10'h010) begin
        bad++; $display("FAIL after_reset data=%h idx=%0d addr=%h want 00000002/0/010", q_data[0], q_idx[0], q_addr[0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 10; i++) mem[i] = 32'(exp_w[i]);
    mem[10'h1F4 >> 2] = 32'hCAFE0001;
    mem[255] = 32'h5A5A0FFC;
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_count();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
